// File: rtl/arty_axi_bram_responder.sv
// rtl/arty_axi_bram_responder.sv - AXI4 memory slave backed by on-chip block RAM
//
// Serves one AXI4 burst at a time (INCR and FIXED, byte strobes) from an
// internal RAM of mem_els_p words. It stands in for the DDR3 controller
// behind the cache-to-AXI DMA bridge.
//
// Optional build macro: ARTY_AXI_BRAM_RESPONDER_DECERR_EN
//   undefined : the word index wraps modulo mem_els_p (upper address bits are
//               ignored) and DECERR is never returned.
//   defined   : word indices >= mem_els_p are out of range. Reads of such a beat
//               return zero data with DECERR. Writes to such a beat are dropped
//               and the burst gets DECERR. DECERR overrides SLVERR.
//
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   s_axi_aw* / s_axi_awready       write address channel
//   s_axi_w*  / s_axi_wready        write data channel
//   s_axi_b*  / s_axi_bready        write response channel
//   s_axi_ar* / s_axi_arready       read address channel
//   s_axi_r*  / s_axi_rready        read data channel

module arty_axi_bram_responder #(
    parameter int axi_addr_width_p = 28,
    parameter int axi_data_width_p = 64,
    parameter int axi_id_width_p   = 4,
    parameter int mem_els_p        = 4096
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [axi_id_width_p-1:0]     s_axi_awid,
    input  logic [axi_addr_width_p-1:0]   s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,

    input  logic [axi_data_width_p-1:0]   s_axi_wdata,
    input  logic [axi_data_width_p/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,

    output logic [axi_id_width_p-1:0]     s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,

    input  logic [axi_id_width_p-1:0]     s_axi_arid,
    input  logic [axi_addr_width_p-1:0]   s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,

    output logic [axi_id_width_p-1:0]     s_axi_rid,
    output logic [axi_data_width_p-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int bytes_lp = axi_data_width_p / 8;
    localparam int off_lp   = $clog2(bytes_lp);
    localparam int widx_lp  = axi_addr_width_p - off_lp;   // full word index
    localparam int idx_lp   = $clog2(mem_els_p);           // RAM index
    localparam logic [2:0] size_lp = 3'(off_lp);

    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;
    localparam logic [1:0] resp_decerr_lp = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        BRESP = 2'd3
    } state_e;

    state_e                        state_q;
    logic                          prio_rd_q;
    logic [axi_id_width_p-1:0]     id_q;
    logic [widx_lp-1:0]            widx_q;
    logic [widx_lp-1:0]            widx_d;
    logic [7:0]                    len_q;
    logic [7:0]                    beat_q;
    logic                          fixed_q;
    logic                          err_q;
    logic                          dec_q;

    logic                          rvalid_q;
    logic [axi_data_width_p-1:0]   rdata_q;
    logic [1:0]                    rresp_q;
    logic                          rlast_q;
    logic                          wready_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;

    logic [axi_data_width_p-1:0]   mem_q [mem_els_p];

    logic [idx_lp-1:0]             mem_idx;
    logic [axi_data_width_p-1:0]   rd_word;
    logic                          oor;
    logic                          ar_fire;
    logic                          aw_fire;
    logic                          w_fire;
    logic                          w_final;
    logic                          wlast_bad;
    logic                          rd_load;
    logic                          mem_we;
    logic                          unused_addr_bits;

    // The sub-word address bits select a byte lane that is never used: every
    // beat is treated as full width.
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign mem_idx = widx_q[idx_lp-1:0];
    assign rd_word = mem_q[mem_idx];

`ifdef ARTY_AXI_BRAM_RESPONDER_DECERR_EN
    assign oor = |(widx_q >> idx_lp);
`else
    assign oor = 1'b0;
`endif

    assign widx_d = fixed_q ? widx_q : widx_q + widx_lp'(1);

    // Address-channel readiness is combinational so that the round-robin
    // decision sees both valids in the same cycle. It is held low during reset.
    assign s_axi_arready = (state_q == IDLE) & ~reset_i & (~s_axi_awvalid | prio_rd_q);
    assign s_axi_awready = (state_q == IDLE) & ~reset_i & (~s_axi_arvalid | ~prio_rd_q);

    assign ar_fire = s_axi_arvalid & s_axi_arready;
    assign aw_fire = s_axi_awvalid & s_axi_awready & ~ar_fire;

    assign w_fire    = (state_q == WR) & s_axi_wvalid & wready_q;
    assign w_final   = (beat_q == len_q);
    assign wlast_bad = s_axi_wlast != w_final;
    assign mem_we    = w_fire & ~oor;

    // Load a beat when the output register is empty, or when the current beat
    // is being taken and it is not the last one (1 beat/cycle streaming).
    assign rd_load = ~rvalid_q | (s_axi_rready & ~rlast_q);

    assign s_axi_wready = wready_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_bid    = id_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rlast_q;
    assign s_axi_rid    = id_q;

    // RAM array has no reset: its contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < bytes_lp; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b1;
            id_q      <= '0;
            widx_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            fixed_q   <= 1'b0;
            err_q     <= 1'b0;
            dec_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= resp_okay_lp;
            rlast_q   <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= resp_okay_lp;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_fire) begin
                        id_q      <= s_axi_arid;
                        widx_q    <= s_axi_araddr[axi_addr_width_p-1:off_lp];
                        len_q     <= s_axi_arlen;
                        beat_q    <= '0;
                        fixed_q   <= (s_axi_arburst == 2'b00);
                        // WRAP and reserved burst types run as INCR but are flagged.
                        err_q     <= (s_axi_arsize != size_lp) | s_axi_arburst[1];
                        dec_q     <= 1'b0;
                        prio_rd_q <= 1'b0;
                        state_q   <= RD;
                    end else if (aw_fire) begin
                        id_q      <= s_axi_awid;
                        widx_q    <= s_axi_awaddr[axi_addr_width_p-1:off_lp];
                        len_q     <= s_axi_awlen;
                        beat_q    <= '0;
                        fixed_q   <= (s_axi_awburst == 2'b00);
                        err_q     <= (s_axi_awsize != size_lp) | s_axi_awburst[1];
                        dec_q     <= 1'b0;
                        prio_rd_q <= 1'b1;
                        wready_q  <= 1'b1;
                        state_q   <= WR;
                    end
                end

                RD: begin
                    if (rd_load) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= oor ? '0 : rd_word;
                        rresp_q  <= oor   ? resp_decerr_lp :
                                    err_q ? resp_slverr_lp : resp_okay_lp;
                        rlast_q  <= (beat_q == len_q);
                        beat_q   <= beat_q + 8'd1;
                        widx_q   <= widx_d;
                    end else if (s_axi_rready) begin
                        // rlast beat taken: burst complete.
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                WR: begin
                    if (w_fire) begin
                        beat_q <= beat_q + 8'd1;
                        widx_q <= widx_d;
                        if (wlast_bad) begin
                            err_q <= 1'b1;
                        end
                        if (oor) begin
                            dec_q <= 1'b1;
                        end
                        // The beat count, not wlast, ends the burst.
                        if (w_final) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (dec_q | oor)         ? resp_decerr_lp :
                                        (err_q | wlast_bad)   ? resp_slverr_lp :
                                                                resp_okay_lp;
                            state_q  <= BRESP;
                        end
                    end
                end

                BRESP: begin
                    if (s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/arty_axi_bram_responder.md
Name: arty_axi_bram_responder

Overview:
- AXI4 full-protocol memory slave backed by on-chip block RAM.
- Terminates the AXI master port of the cache-to-AXI DMA bridge, in place of the MIG/DDR3 subsystem.
- Used for DDR-less FPGA bring-up and for fast simulation of the unicore memory path.
- Serves one burst at a time: INCR and FIXED, with byte strobes.

Parameters:
- axi_addr_width_p, 28, AXI address width.
- axi_data_width_p, 64, data width in bits; must be a power of 2, at least 8.
- axi_id_width_p, 4, AXI ID width.
- mem_els_p, 4096, memory depth in data words; must be a power of 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  id/addr/8/3/2  write address channel.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write address handshake.
- s_axi_wdata/wstrb/wlast  in  data/data/8/1  write data channel.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write data handshake.
- s_axi_bid/bresp  out  id/2  write response channel.
- s_axi_bvalid  out  1 / s_axi_bready  in  1  write response handshake.
- s_axi_arid/araddr/arlen/arsize/arburst  in  id/addr/8/3/2  read address channel.
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read address handshake.
- s_axi_rid/rdata/rresp/rlast  out  id/data/2/1  read data channel.
- s_axi_rvalid  out  1 / s_axi_rready  in  1  read data handshake.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-high, on reset_i.
- Reset values:
  - All valid/ready outputs 0.
  - rdata, rid, bid, rresp, bresp, rlast all 0.
  - FSM goes to IDLE; read priority flag set to "read first".
  - Memory contents are not reset.
- FSM states: IDLE, RD, WR, BRESP.
- IDLE:
  - arready = ~awvalid | prio_rd; awready = ~arvalid | ~prio_rd.
  - The accepted channel latches id, word index (addr >> log2(data bytes)), len, and burst type.
  - On accept, prio_rd flips to the other channel (round-robin when both are valid in the same cycle).
  - AR accept goes to RD; AW accept goes to WR.
- Word index wraps modulo mem_els_p: aliasing, upper bits ignored.
- awsize/arsize other than log2(data bytes) is accepted and the beat is treated as full width. This sets the error flag, which yields SLVERR on that burst.
- Burst types:
  - INCR increments the index by 1 per beat, wrapping modulo mem_els_p.
  - FIXED holds the index.
  - WRAP and reserved types behave as INCR and set the error flag.
- RD:
  - Synchronous BRAM read. First rvalid exactly 1 cycle after the AR handshake.
  - Each rvalid&rready handshake advances to the next beat; the next beat is valid the following cycle, so back-to-back beats stream at 1 beat/cycle.
  - rdata/rid/rresp/rlast are held stable while rvalid & ~rready.
  - rlast is high on beat len. rresp is OKAY (00), or SLVERR (10) if the error flag is set.
  - The last handshake returns to IDLE.
- WR:
  - wready = 1. Each wvalid&wready handshake writes the bytes enabled by wstrb at the current index; wstrb=0 writes nothing.
  - The beat counter ends the burst at len+1 beats regardless of wlast.
  - A wlast mismatch (early, or missing on the final beat) sets the error flag.
  - After the final beat: go to BRESP; wready drops the next cycle.
- BRESP: bvalid=1, bid = latched id, bresp = OKAY or SLVERR. On bready, go to IDLE.
- Error flag clears on each new AR/AW accept.
- No outstanding-transaction queue; one burst in flight. Ready is never asserted outside the channel's active state.
- Read-after-write to the same word in consecutive bursts returns the new data; the BRAM write precedes the read by at least 1 cycle.
- Reset mid-burst:
  - The burst is abandoned immediately (asynchronous); no response is issued.
  - Partially written beats remain in memory.

Optional Feature:
- Macro: ARTY_AXI_BRAM_RESPONDER_DECERR_EN.
- Defined:
  - Addresses with word index >= mem_els_p (any upper address bit set) are decoded as out of range; there is no aliasing.
  - Out-of-range read beats return rdata=0 with rresp=DECERR (11).
  - Out-of-range write beats are dropped; bresp=DECERR if any beat was out of range.
  - Beat timing is unchanged.
  - DECERR takes precedence over SLVERR.
- Undefined: aliasing as in Behaviour; DECERR is never produced.

Test Plan:
- Write then read:
  - Stimulus: AW addr=0x40, len=3, INCR; data 0x11..11 through 0x44..44, wstrb=FF, wlast on beat 3; then AR same addr/len.
  - Required: bresp=00, bid matches; 4 read beats in 4 consecutive cycles with matching data; rlast only on beat 4.
- Byte strobes:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF at 0x0; then write 0x0 with wstrb=0x0F; then read 0x0.
  - Required: rdata=0xFFFF_FFFF_0000_0000.
- Simultaneous channels:
  - Stimulus: arvalid and awvalid asserted together, twice in succession after reset.
  - Required: read served first, write second; next collision serves write first.
- Read backpressure:
  - Stimulus: AR len=3; rready toggles 1,0,0,1,...
  - Required: rdata/rlast held stable during stalls; all 4 beats correct; FSM returns to IDLE only after the rlast handshake.
- Protocol error:
  - Stimulus: AW len=3 with wlast on beat 1.
  - Required: 4 beats consumed; bresp=10. Also, an AR with arburst=WRAP returns rresp=10 on every beat.
- Reset and aliasing:
  - Stimulus: reset_i pulsed mid-read.
  - Required: rvalid=0 asynchronously; a new AR is accepted after release.
  - Stimulus (macro off): address mem_els_p*8.
  - Required: aliases to word 0.
  - Stimulus (macro on): same address.
  - Required: rresp=11, rdata=0.
